srl_pulse_sched: RTL and testbench
==================================

Name: srl_pulse_sched

Overview:
- Clocked scheduler that shares a bank of M set/reset latches (SRL cells) between N requesters.
- Arbitrates requests round-robin and drives a single set or reset pulse of fixed width, then holds a guard gap.
- Reads back the latch output through a 2-flop synchroniser and acks the requester with a pass/fail flag.
- Sits between synchronous control logic and the asynchronous latch bank; it is the only driver of the bank's s/r inputs.

Parameters:
- N, 4, number of requesters (≥1).
- M, 8, number of SRL cells in the bank (≥1).
- IDXW, 3, width of a latch index (≥ clog2(M), ≥1).
- PULSE_W, 2, cycles s or r is held high (≥1).
- GAP, 3, idle cycles after the pulse before readback (≥2, covers the synchroniser).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  request per requester; held until its ack.
- req_op  in  N  per requester: 1 = set, 0 = reset; stable while req is high.
- req_idx  in  N*IDXW  per requester target latch index, requester i at bits [i*IDXW +: IDXW]; stable while req is high.
- ack  out  N  one-cycle pulse to the served requester.
- err  out  1  valid with ack: 1 = readback mismatch or index out of range.
- busy  out  1  high in any state other than IDLE.
- srl_s  out  M  set strobes to the latch bank.
- srl_r  out  M  reset strobes to the latch bank.
- srl_q  in  M  latch outputs, asynchronous to clk.

Behaviour:
- All outputs are registered.
- Reset, asserted asynchronously at any time including mid-pulse:
  - srl_s, srl_r, ack, err and busy go to 0 immediately.
  - state = IDLE, round-robin pointer = 0, synchroniser flops = 0.
  - Latch contents are not touched.
- srl_q[M-1:0] passes through 2 flops to give q_sync; no other path uses srl_q.
- Invariant: across srl_s and srl_r together, at most one bit is high in any cycle. srl_s[k] and srl_r[k] are never both high.
- States: IDLE, PULSE, GAP, CHECK.
- IDLE:
  - On an edge with any req high, pick the winner: the first requester with req high, searching from ptr upward with wrap.
  - Capture win, op and idx (capture edge = cycle 0).
  - If idx < M, go to PULSE. Otherwise go to CHECK with a forced error.
  - busy is 1 from cycle 1.
- PULSE:
  - Cycles 1..PULSE_W: srl_s[idx] = 1 if op = 1, else srl_r[idx] = 1.
  - Then go to GAP.
- GAP:
  - PULSE_W+1 .. PULSE_W+GAP: all strobes 0.
  - Then go to CHECK.
- CHECK (cycle PULSE_W+GAP+1; cycle 1 for an out-of-range index):
  - ack[win] = 1.
  - err = (q_sync[idx] != op), or 1 if the index was out of range.
  - ptr = (win+1) mod N.
  - Next state IDLE.
- Back-to-back: a request pending in IDLE is captured on the edge after CHECK. Latency per request is PULSE_W+GAP+2 edges from the previous capture.
- Requests that rise while busy wait; none are lost.
- Dropping req before ack does not abort a captured operation; the ack is still issued.
- Simultaneous requests for the same idx are served sequentially in round-robin order. The last one served defines the latch state.
- Set on an already-set latch still pulses and acks with err = 0.

Test Plan:
- N=4, M=8, PULSE_W=2, GAP=3; req[1]=1, op=1, idx=5 captured at cycle 0 -> srl_s[5]=1 in cycles 1-2, strobes 0 in cycles 3-5; srl_q[5] tied high -> ack[1]=1 with err=0 at cycle 6 only; busy=1 in cycles 1-6.
- Same request, but srl_q[5] held low -> ack[1] at cycle 6 with err=1.
- req=4'b1111 all held, ptr=0 -> grant order 0,1,2,3,0; each ack 7 cycles after the previous; srl_s/srl_r never more than one bit high.
- req[2]=1, idx=7 then idx=6 with M=6 -> idx 7 gives ack[2] with err=1 at cycle 1 and no strobe; idx=6 (also out of range) gives the same response.
- rst asserted during cycle 2 of a reset pulse (srl_r[3]=1) -> srl_r=0 and busy=0 without waiting for a clock edge; after release, a fresh request to requester 0 wins (ptr=0).
- req[0] op=0 idx=2 and req[3] op=1 idx=2 together, ptr=3 -> requester 3 set served first, then requester 0 reset; final srl_q[2]=0, both acks have err=0.

Source files
------------

// File: rtl/srl_pulse_sched.sv
// srl_pulse_sched: round-robin scheduler that owns the s/r strobes of a bank
// of asynchronous set/reset latch cells. Each request produces one fixed-width
// set or reset pulse and a guard gap. The cell is then read back through a
// 2-flop synchroniser, and the requester is acked with a pass/fail flag.
module srl_pulse_sched #(
    parameter int N       = 4,
    parameter int M       = 8,
    parameter int IDXW    = 3,
    parameter int PULSE_W = 2,
    parameter int GAP     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N-1:0]        req_op,
    input  logic [N*IDXW-1:0]   req_idx,
    output logic [N-1:0]        ack,
    output logic                err,
    output logic                busy,
    output logic [M-1:0]        srl_s,
    output logic [M-1:0]        srl_r,
    input  logic [M-1:0]        srl_q
);
    localparam int PW      = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_MAX = (PULSE_W > GAP) ? PULSE_W : GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [IDXW:0] M_LIM = (IDXW + 1)'(M);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    // One-hot strobe vector for a cell index (all zero if out of range).
    function automatic logic [M-1:0] cell_onehot(input logic [IDXW-1:0] i);
        logic [M-1:0] r;
        r = {M{1'b0}};
        for (int k = 0; k < M; k++) begin
            r[k] = (i == IDXW'(k));
        end
        return r;
    endfunction

    // One-hot ack vector for a requester number.
    function automatic logic [N-1:0] req_onehot(input logic [PW-1:0] w);
        logic [N-1:0] r;
        r = {N{1'b0}};
        for (int k = 0; k < N; k++) begin
            r[k] = (w == PW'(k));
        end
        return r;
    endfunction

    // Select one bit of the synchronised readback by cell index.
    function automatic logic cell_bit(input logic [M-1:0] v, input logic [IDXW-1:0] i);
        logic r;
        r = 1'b0;
        for (int k = 0; k < M; k++) begin
            if (i == IDXW'(k)) begin
                r = v[k];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic              op_q, op_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              oor_q, oor_d;
    logic [M-1:0]      sync1_q, sync2_q;

    logic [N-1:0]      ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [M-1:0]      srl_s_q, srl_s_d;
    logic [M-1:0]      srl_r_q, srl_r_d;

    logic              found_s;
    logic [PW-1:0]     grant_s;
    int                cand_s;
    logic              sel_op_s;
    logic [IDXW-1:0]   sel_idx_s;

    // Round-robin search: first requester with req high starting at ptr.
    always_comb begin
        found_s = 1'b0;
        grant_s = {PW{1'b0}};
        cand_s  = 0;
        for (int j = 0; j < N; j++) begin
            cand_s = (int'(ptr_q) + j) % N;
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                grant_s = PW'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
        sel_op_s  = req_op[grant_s];
        sel_idx_s = req_idx[int'(grant_s) * IDXW +: IDXW];
    end

    // Next-state logic for the IDLE/PULSE/GAP/CHECK sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_d    = op_q;
        idx_d   = idx_q;
        oor_d   = oor_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    win_d   = grant_s;
                    op_d    = sel_op_s;
                    idx_d   = sel_idx_s;
                    oor_d   = !({1'b0, sel_idx_s} < M_LIM);
                    cnt_d   = {CW{1'b0}};
                    state_d = ({1'b0, sel_idx_s} < M_LIM) ? ST_PULSE : ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == CW'(PULSE_W - 1)) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_GAP;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CW'(GAP - 1)) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_CHECK;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_CHECK: begin
                ptr_d   = (int'(win_q) == N - 1) ? {PW{1'b0}} : win_q + PW'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the state being entered.
    always_comb begin
        srl_s_d = {M{1'b0}};
        srl_r_d = {M{1'b0}};
        ack_d   = {N{1'b0}};
        err_d   = 1'b0;
        busy_d  = (state_d != ST_IDLE);
        if (state_d == ST_PULSE) begin
            if (op_d) begin
                srl_s_d = cell_onehot(idx_d);
            end else begin
                srl_r_d = cell_onehot(idx_d);
            end
        end else begin
            srl_s_d = {M{1'b0}};
        end
        if (state_d == ST_CHECK) begin
            ack_d = req_onehot(win_d);
            err_d = oor_d ? 1'b1 : (cell_bit(sync2_q, idx_d) != op_d);
        end else begin
            ack_d = {N{1'b0}};
        end
    end

    // Two-flop synchroniser for the asynchronous latch outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= {M{1'b0}};
            sync2_q <= {M{1'b0}};
        end else begin
            sync1_q <= srl_q;
            sync2_q <= sync1_q;
        end
    end

    // Sequencer state, counter, round-robin pointer and captured request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            ptr_q   <= {PW{1'b0}};
            win_q   <= {PW{1'b0}};
            op_q    <= 1'b0;
            idx_q   <= {IDXW{1'b0}};
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            oor_q   <= oor_d;
        end
    end

    // Registered outputs; reset clears strobes immediately, even mid-pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            srl_s_q <= {M{1'b0}};
            srl_r_q <= {M{1'b0}};
            ack_q   <= {N{1'b0}};
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            srl_s_q <= srl_s_d;
            srl_r_q <= srl_r_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign srl_s = srl_s_q;
    assign srl_r = srl_r_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_srl_pulse_sched.sv
// Testbench for srl_pulse_sched: a cycle-level reference model plus directed
// scenarios with hand-computed expectations. Instance A uses the default
// configuration with a modelled latch bank; instance B has M=6 and checks
// out-of-range indices.
module tb_srl_pulse_sched;
    localparam int PULSE_W = 2;
    localparam int GAP     = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'h0, req_op = 4'h0;
    logic [11:0] req_idx = 12'h000;
    logic [3:0]  ack;
    logic        err, busy;
    logic [7:0]  srl_s, srl_r, srl_q;

    logic [3:0]  req_b = 4'h0, req_op_b = 4'h0;
    logic [11:0] req_idx_b = 12'h000;
    logic [3:0]  ack_b;
    logic        err_b, busy_b;
    logic [5:0]  srl_s_b, srl_r_b;
    logic [5:0]  srl_q_b = 6'h00;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    srl_pulse_sched #(.N(4), .M(8), .IDXW(3), .PULSE_W(PULSE_W), .GAP(GAP)) dut_a (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_idx(req_idx),
        .ack(ack), .err(err), .busy(busy), .srl_s(srl_s), .srl_r(srl_r), .srl_q(srl_q));

    srl_pulse_sched #(.N(4), .M(6), .IDXW(3), .PULSE_W(PULSE_W), .GAP(GAP)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_op(req_op_b), .req_idx(req_idx_b),
        .ack(ack_b), .err(err_b), .busy(busy_b), .srl_s(srl_s_b), .srl_r(srl_r_b), .srl_q(srl_q_b));

    // Latch bank behaviour: a strobe sets/clears its cell; forcing masks override readback.
    logic [7:0] bank = 8'h00;
    logic [7:0] force_hi = 8'h00, force_lo = 8'h00;
    always @(negedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (srl_s[k]) bank[k] <= 1'b1;
            else if (srl_r[k]) bank[k] <= 1'b0;
        end
    end
    assign srl_q = (bank | force_hi) & ~force_lo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction starts at the capture edge and the cycle
    // number t since capture determines every output.
    bit         m_active = 1'b0;
    int         m_t = 0, m_end = 0, m_win = 0, m_idx = 0, m_ptr = 0;
    bit         m_op = 1'b0, m_oor = 1'b0, m_err = 1'b0;
    logic [7:0] m_s1 = 8'h00, m_s2 = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0; m_t = 0; m_ptr = 0; m_s1 = 8'h00; m_s2 = 8'h00;
        end else begin
            if (m_active) begin
                if (m_t == m_end) begin
                    m_active = 1'b0;
                    m_ptr = (m_win + 1) % 4;
                end else begin
                    m_t++;
                    if (m_t == m_end) m_err = m_oor ? 1'b1 : (m_s2[m_idx] != m_op);
                end
            end else if (req != 4'h0) begin
                for (int j = 3; j >= 0; j--) begin
                    if (req[(m_ptr + j) % 4]) m_win = (m_ptr + j) % 4;
                end
                m_op     = req_op[m_win];
                m_idx    = int'(req_idx[m_win*3 +: 3]);
                m_oor    = (m_idx >= 8);
                m_active = 1'b1;
                m_t      = 1;
                m_end    = m_oor ? 1 : PULSE_W + GAP + 1;
                m_err    = 1'b1;
            end
            m_s2 = m_s1;
            m_s1 = srl_q;
        end
    end

    // Per-cycle comparison of instance A against the model.
    always @(negedge clk) begin
        logic [7:0] e_str;
        logic [3:0] e_ack;
        e_str = (m_active && !m_oor && m_t <= PULSE_W) ? (8'h01 << m_idx) : 8'h00;
        e_ack = (m_active && m_t == m_end) ? (4'h1 << m_win) : 4'h0;
        chk("m_busy", 32'(busy), 32'(m_active));
        chk("m_srl_s", 32'(srl_s), m_op ? 32'(e_str) : 32'h0);
        chk("m_srl_r", 32'(srl_r), m_op ? 32'h0 : 32'(e_str));
        chk("m_ack", 32'(ack), 32'(e_ack));
        if (e_ack != 4'h0) chk("m_err", 32'(err), 32'(m_err));
        if (($countones(srl_s) + $countones(srl_r)) > 1) chk("onehot_strobes", 32'(srl_s | srl_r), 32'(e_str));
    end

    // Wait (bounded) for an ack on instance A; k counts negedges from the call.
    task automatic wait_ack(output int cyc, output logic [3:0] a, output logic e, output logic [7:0] st1);
        cyc = 0; a = 4'h0; e = 1'b0; st1 = 8'h00;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) st1 = srl_s | srl_r;
            if (ack != 4'h0) begin
                cyc = k; a = ack; e = err;
                break;
            end
        end
        if (cyc == 0) begin
            total++; bad++;
            $display("FAIL ack_timeout: got no ack expected ack within 40 cycles");
        end
    endtask

    int         cyc;
    logic [3:0] a;
    logic       e;
    logic [7:0] st1;
    int         exp_win[5] = '{0, 1, 2, 3, 0};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_strobes", 32'(srl_s | srl_r), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // All four held, ptr=0: grant order 0,1,2,3,0 at 7-cycle spacing.
        req_op  = 4'b1011;
        req_idx = {3'd7, 3'd2, 3'd1, 3'd0};
        req     = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_ack(cyc, a, e, st1);
            chk("rr_gap", 32'(cyc), (g == 0) ? 32'd6 : 32'd7);
            chk("rr_ack", 32'(a), 32'(4'h1 << exp_win[g]));
            chk("rr_err", 32'(e), 32'h0);
            if (g == 4) req = 4'h0;
        end
        @(negedge clk);
        chk("rr_bank", 32'(srl_q), 32'h83);

        // Requester 1 sets cell 5 with the readback tied high.
        force_hi = 8'h20;
        req_op = 4'b0010; req_idx = {3'd0, 3'd0, 3'd5, 3'd0}; req = 4'b0010;
        wait_ack(cyc, a, e, st1);
        req = 4'h0;
        chk("t1_pulse", 32'(st1), 32'h20);
        chk("t1_cyc", 32'(cyc), 32'd6);
        chk("t1_ack", 32'(a), 32'h2);
        chk("t1_err", 32'(e), 32'h0);
        @(negedge clk);
        chk("t1_idle", 32'(busy), 32'h0);
        force_hi = 8'h00;

        // Same request with the readback held low: mismatch flagged.
        force_lo = 8'h20;
        req = 4'b0010;
        wait_ack(cyc, a, e, st1);
        req = 4'h0;
        chk("t2_cyc", 32'(cyc), 32'd6);
        chk("t2_ack", 32'(a), 32'h2);
        chk("t2_err", 32'(e), 32'h1);
        @(negedge clk);
        force_lo = 8'h00;

        // Serve requester 2 once so that ptr becomes 3.
        req_op = 4'b0100; req_idx = {3'd0, 3'd4, 3'd0, 3'd0}; req = 4'b0100;
        wait_ack(cyc, a, e, st1);
        req = 4'h0;
        chk("t6_pre_ack", 32'(a), 32'h4);
        @(negedge clk);

        // Reset on cell 2 from requester 0 and set from requester 3, ptr=3.
        req_op = 4'b1000; req_idx = {3'd2, 3'd0, 3'd0, 3'd2}; req = 4'b1001;
        wait_ack(cyc, a, e, st1);
        req = 4'b0001;
        chk("t6_first", 32'(a), 32'h8);
        chk("t6_first_err", 32'(e), 32'h0);
        chk("t6_mid_q", 32'(srl_q[2]), 32'h1);
        wait_ack(cyc, a, e, st1);
        req = 4'h0;
        chk("t6_second", 32'(a), 32'h1);
        chk("t6_second_gap", 32'(cyc), 32'd7);
        chk("t6_second_err", 32'(e), 32'h0);
        @(negedge clk);
        chk("t6_final_q", 32'(srl_q[2]), 32'h0);

        // Reset asserted during cycle 2 of a reset pulse on cell 3.
        req_op = 4'b0000; req_idx = {3'd3, 3'd0, 3'd0, 3'd0}; req = 4'b1000;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("t5_pulse", 32'(srl_r), 32'h08);
        rst = 1'b1;
        #1;
        chk("t5_rst_srl_r", 32'(srl_r), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        req_op = 4'b0001; req_idx = {3'd3, 3'd0, 3'd0, 3'd6}; req = 4'b1001;
        wait_ack(cyc, a, e, st1);
        req = 4'b1000;
        chk("t5_after_ack", 32'(a), 32'h1);
        chk("t5_after_cyc", 32'(cyc), 32'd6);
        wait_ack(cyc, a, e, st1);
        req = 4'h0;
        chk("t5_next_ack", 32'(a), 32'h8);
        @(negedge clk);

        // Instance B (M=6): indices 7 and 6 are out of range.
        for (int t = 0; t < 2; t++) begin
            req_op_b  = 4'b0100;
            req_idx_b = {3'd0, (t == 0) ? 3'd7 : 3'd6, 3'd0, 3'd0};
            req_b     = 4'b0100;
            @(negedge clk);
            req_b = 4'h0;
            chk("oor_ack", 32'(ack_b), 32'h4);
            chk("oor_err", 32'(err_b), 32'h1);
            chk("oor_busy", 32'(busy_b), 32'h1);
            chk("oor_strobe", 32'(srl_s_b | srl_r_b), 32'h0);
            @(negedge clk);
            chk("oor_done", 32'({ack_b, busy_b}), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
